// File: rtl/td_capture_writer.sv
// td_capture_writer: decodes the TV-decoder sync stream on TD_CLK and writes a
// fixed WIN_W x WIN_H window of each captured frame into the frame buffer.
// Write address is row/column concatenation, so WIN_W must be a power of two.
module td_capture_writer #(
    parameter int unsigned H_START = 250,
    parameter int unsigned V_START = 90,
    parameter int unsigned WIN_W   = 128,
    parameter int unsigned WIN_H   = 256,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              TD_CLK,
    input  logic              reset,
    input  logic              TD_HS,
    input  logic              TD_VS,
    input  logic [DATA_W-1:0] td_data,
    input  logic              cap_en,
    input  logic              cap_cont,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_short
);

    localparam int unsigned PIX_W  = 11;
    localparam int unsigned LIN_W  = 10;
    localparam int unsigned ROWC_W = LIN_W + 1;
    localparam int unsigned COL_W  = $clog2(WIN_W);
    localparam int unsigned FULL_W = LIN_W + COL_W;

    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [LIN_W-1:0] LIN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // sync / data pipeline
    logic              s1_hs_q;
    logic              s1_vs_q;
    logic              s2_hs_q;
    logic              s2_vs_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              hs_fall;
    logic              vs_fall;

    // pixel / line position of the current stage-1 sample
    logic [PIX_W-1:0]  pix_q;
    logic [PIX_W-1:0]  pix_d;
    logic [LIN_W-1:0]  lin_q;
    logic [LIN_W-1:0]  lin_d;

    // window decode
    logic [PIX_W-1:0]  col_off;
    logic [LIN_W-1:0]  row_off;
    logic              h_hit;
    logic              v_hit;
    logic              in_win;
    logic              win_end;
    logic [FULL_W-1:0] win_full;
    logic [ADDR_W-1:0] win_addr;

    // control
    state_e            state_q;
    state_e            state_d;
    logic              short_hit;

    // registered outputs
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] wr_data_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic              busy_q;
    logic              busy_d;
    logic              frame_done_q;
    logic              frame_done_d;
    logic              frame_short_q;
    logic              frame_short_d;

    // Two-stage sync pipeline; syncs reset to the inactive level so no edge fires.
    always_ff @(posedge TD_CLK) begin
        if (reset) begin
            s1_hs_q   <= 1'b1;
            s1_vs_q   <= 1'b1;
            s2_hs_q   <= 1'b1;
            s2_vs_q   <= 1'b1;
            s1_data_q <= '0;
        end else begin
            s1_hs_q   <= TD_HS;
            s1_vs_q   <= TD_VS;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            s1_data_q <= td_data;
        end
    end

    // Falling-edge detect on the active-low syncs.
    always_comb begin
        hs_fall = s2_hs_q & ~s1_hs_q;
        vs_fall = s2_vs_q & ~s1_vs_q;
    end

    // Saturating pixel/line counters; vs_fall has priority over hs_fall.
    always_comb begin
        pix_d = pix_q;
        lin_d = lin_q;
        if (hs_fall) begin
            pix_d = '0;
        end else if (pix_q != PIX_MAX) begin
            pix_d = pix_q + PIX_W'(1);
        end
        if (vs_fall) begin
            lin_d = '0;
        end else if (hs_fall && (lin_q != LIN_MAX)) begin
            lin_d = lin_q + LIN_W'(1);
        end
    end

    // Position counter registers.
    always_ff @(posedge TD_CLK) begin
        if (reset) begin
            pix_q <= '0;
            lin_q <= '0;
        end else begin
            pix_q <= pix_d;
            lin_q <= lin_d;
        end
    end

    // Window hit and address; offsets wrap below the start so one compare suffices.
    always_comb begin
        col_off  = pix_d - PIX_W'(H_START);
        row_off  = lin_d - LIN_W'(V_START);
        h_hit    = col_off < PIX_W'(WIN_W);
        v_hit    = {1'b0, row_off} < ROWC_W'(WIN_H);
        in_win   = h_hit & v_hit;
        win_end  = hs_fall & ~vs_fall & (lin_d == LIN_W'(V_START + WIN_H));
        win_full = {row_off, col_off[COL_W-1:0]};
        win_addr = ADDR_W'(win_full);
    end

    // FSM state register.
    always_ff @(posedge TD_CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a VS fall before the window completes marks the frame short.
    always_comb begin
        state_d   = state_q;
        short_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cap_en) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!cap_en) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vs_fall) begin
                    state_d   = S_DONE;
                    short_hit = 1'b1;
                end else if (win_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = (cap_en && cap_cont) ? S_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs; status tracks the next state so it lines up with state_q.
    always_comb begin
        wr_en_d       = in_win & (state_q == S_ACTIVE);
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = (state_d == S_ARM) || (state_d == S_ACTIVE);
        frame_done_d  = (state_d == S_DONE);
        frame_short_d = short_hit;
        if (wr_en_d) begin
            wr_addr_d = win_addr;
            wr_data_d = s1_data_q;
        end
    end

    // Output registers.
    always_ff @(posedge TD_CLK) begin
        if (reset) begin
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_short_q <= 1'b0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_short_q <= frame_short_d;
        end
    end

    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_en       = wr_en_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_short = frame_short_q;

endmodule
